// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory op codes, access-size encodings,
// FSM state encoding and the op decoder.
package mem_access_pkg;

    localparam int OPC_W = 8;

    localparam logic [OPC_W-1:0] OP_LB  = 8'h10;
    localparam logic [OPC_W-1:0] OP_LH  = 8'h11;
    localparam logic [OPC_W-1:0] OP_LW  = 8'h12;
    localparam logic [OPC_W-1:0] OP_LBU = 8'h13;
    localparam logic [OPC_W-1:0] OP_LHU = 8'h14;
    localparam logic [OPC_W-1:0] OP_SB  = 8'h18;
    localparam logic [OPC_W-1:0] OP_SH  = 8'h19;
    localparam logic [OPC_W-1:0] OP_SW  = 8'h1A;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       is_mem;
        logic       is_load;
        logic       is_unsigned;
        logic [1:0] size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [OPC_W-1:0] op);
        mem_op_t d;
        d = '{1'b0, 1'b0, 1'b0, SIZE_B};
        case (op)
            OP_LB:   d = '{1'b1, 1'b1, 1'b0, SIZE_B};
            OP_LH:   d = '{1'b1, 1'b1, 1'b0, SIZE_H};
            OP_LW:   d = '{1'b1, 1'b1, 1'b0, SIZE_W};
            OP_LBU:  d = '{1'b1, 1'b1, 1'b1, SIZE_B};
            OP_LHU:  d = '{1'b1, 1'b1, 1'b1, SIZE_H};
            OP_SB:   d = '{1'b1, 1'b0, 1'b0, SIZE_B};
            OP_SH:   d = '{1'b1, 1'b0, 1'b0, SIZE_H};
            OP_SW:   d = '{1'b1, 1'b0, 1'b0, SIZE_W};
            default: d = '{1'b0, 1'b0, 1'b0, SIZE_B};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: combinational load sign/zero extension and store data masking.
module mem_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_ld_size,
    input  logic            i_ld_unsigned,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_st_size,
    input  logic [XLEN-1:0] i_st_data,
    output logic [XLEN-1:0] o_ld_data,
    output logic [XLEN-1:0] o_st_data
);

    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_size)
            SIZE_B:  o_ld_data = {{(XLEN-8){~i_ld_unsigned & i_rdata[7]}}, i_rdata[7:0]};
            SIZE_H:  o_ld_data = {{(XLEN-16){~i_ld_unsigned & i_rdata[15]}}, i_rdata[15:0]};
            default: o_ld_data = i_rdata;
        endcase
    end

    always_comb begin
        o_st_data = i_st_data;
        case (i_st_size)
            SIZE_B:  o_st_data = {{(XLEN-8){1'b0}}, i_st_data[7:0]};
            SIZE_H:  o_st_data = {{(XLEN-16){1'b0}}, i_st_data[15:0]};
            default: o_st_data = i_st_data;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores to mem_ctrl and stalls until done.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [OP_W-1:0]       op_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [XLEN-1:0]       st_data_i,
    output logic                  mem_stall_req,
    output logic                  mem_req,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    input  logic                  mem_gnt,
    input  logic                  mem_done,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic                  misalign_o
);

    state_t                r_state;
    state_t                w_state_next;
    logic [OPC_W-1:0]      w_op8;
    logic                  w_op_hi_zero;
    mem_op_t               w_dec;
    logic                  w_is_mem;
    logic                  w_misalign;
    logic                  w_start;
    logic                  w_done;
    logic                  w_stall;
    logic                  w_req;
    logic [XLEN-1:0]       w_ld_data;
    logic [XLEN-1:0]       w_st_masked;

    logic                  r_is_load;
    logic                  r_unsigned;
    logic [REG_ADDR_W-1:0] r_ld_wd;
    logic [XLEN-1:0]       r_mem_addr;
    logic [XLEN-1:0]       r_mem_wdata;
    logic                  r_mem_we;
    logic [1:0]            r_mem_size;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [XLEN-1:0]       r_wdata;

    // Op codes wider than the shared table only match when the extra bits are zero.
    generate
        if (OP_W > OPC_W) begin : g_wide_op
            assign w_op_hi_zero = ~|op_i[OP_W-1:OPC_W];
        end else begin : g_narrow_op
            assign w_op_hi_zero = 1'b1;
        end
    endgenerate

    assign w_op8    = OPC_W'(op_i);
    assign w_dec    = decode_op(w_op8);
    assign w_is_mem = w_dec.is_mem & w_op_hi_zero;

`ifdef MEM_MISALIGN_CHK_EN
    logic r_misalign;

    assign w_misalign = w_is_mem &
                        (((w_dec.size == SIZE_H) & wdata_i[0]) |
                         ((w_dec.size == SIZE_W) & (|wdata_i[1:0])));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == ST_IDLE) & in_valid & w_misalign;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign w_misalign = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign w_start = in_valid & w_is_mem & ~w_misalign;

    mem_align #(.XLEN(XLEN)) u_align (
        .i_ld_size     (r_mem_size),
        .i_ld_unsigned (r_unsigned),
        .i_rdata       (mem_rdata),
        .i_st_size     (w_dec.size),
        .i_st_data     (st_data_i),
        .o_ld_data     (w_ld_data),
        .o_st_data     (w_st_masked)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall drops in the completion cycle so upstream advances on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_req        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_REQ;
                    w_stall      = 1'b1;
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (mem_gnt) begin
                    w_done       = mem_done;
                    w_state_next = mem_done ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_load   <= 1'b0;
            r_unsigned  <= 1'b0;
            r_ld_wd     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= SIZE_B;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_wreg <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (in_valid && !w_is_mem) begin
                    r_wd    <= wd_i;
                    r_wreg  <= wreg_i;
                    r_wdata <= wdata_i;
                end else if (w_start) begin
                    r_is_load   <= w_dec.is_load;
                    r_unsigned  <= w_dec.is_unsigned;
                    r_ld_wd     <= wd_i;
                    r_mem_addr  <= wdata_i;
                    r_mem_wdata <= w_st_masked;
                    r_mem_we    <= ~w_dec.is_load;
                    r_mem_size  <= w_dec.size;
                end
            end else if (w_done) begin
                r_wd   <= r_ld_wd;
                r_wreg <= r_is_load;
                if (r_is_load) begin
                    r_wdata <= w_ld_data;
                end
            end
        end
    end

    assign mem_stall_req = w_stall;
    assign mem_req       = w_req;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_we        = r_mem_we;
    assign mem_size      = r_mem_size;
    assign wd_o          = r_wd;
    assign wreg_o        = r_wreg;
    assign wdata_o       = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access; expectations follow the defined/undefined
// state of MEM_MISALIGN_CHK_EN.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADDI = 8'h02;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  op_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [31:0] st_data_i = '0;
    logic        mem_stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_gnt = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_access #(.XLEN(32), .REG_ADDR_W(5), .OP_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .op_i          (op_i),
        .wd_i          (wd_i),
        .wreg_i        (wreg_i),
        .wdata_i       (wdata_i),
        .st_data_i     (st_data_i),
        .mem_stall_req (mem_stall_req),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .mem_gnt       (mem_gnt),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .wd_o          (wd_o),
        .wreg_o        (wreg_o),
        .wdata_o       (wdata_o),
        .misalign_o    (misalign_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdat, input logic [31:0] st);
        in_valid  = v;
        op_i      = op;
        wd_i      = wd;
        wreg_i    = wr;
        wdata_i   = wdat;
        st_data_i = st;
    endtask

    // Load with grant and done in the same cycle as the request.
    task automatic load_once(input string tag, input logic [7:0] op, input logic [31:0] rdata,
                             input logic [31:0] exp);
        drive(1'b1, op, 5'd12, 1'b0, 32'h0000_0500, 32'h0);
        #1;
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        mem_gnt   = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = rdata;
        #1;
        tick;
        mem_gnt  = 1'b0;
        mem_done = 1'b0;
        check(tag, wdata_o, exp);
    endtask

    task automatic store_once(input string tag, input logic [7:0] op, input logic [31:0] st,
                              input logic [31:0] exp_data, input logic [1:0] exp_size);
        drive(1'b1, op, 5'd0, 1'b0, 32'h0000_0600, st);
        #1;
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        check({tag, "_data"}, mem_wdata, exp_data);
        check({tag, "_size"}, {30'd0, mem_size}, {30'd0, exp_size});
        mem_gnt  = 1'b1;
        mem_done = 1'b1;
        #1;
        tick;
        mem_gnt  = 1'b0;
        mem_done = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_stall", {31'd0, mem_stall_req}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we_size", {29'd0, mem_we, mem_size}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wb", {26'd0, wd_o, wreg_o}, 32'd0);
        check("rst_wdata_o", wdata_o, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        rst = 1'b1;

        // ADD: one-cycle pass-through, no stall
        drive(1'b1, OP_ADD, 5'd5, 1'b1, 32'h0000_0010, 32'h0);
        #1;
        check("add_stall", {31'd0, mem_stall_req}, 32'd0);
        tick;
        check("add_wd", {27'd0, wd_o}, 32'd5);
        check("add_wreg", {31'd0, wreg_o}, 32'd1);
        check("add_wdata", wdata_o, 32'h10);
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        #1;
        check("idle_stall", {31'd0, mem_stall_req}, 32'd0);
        tick;
        check("idle_wreg", {31'd0, wreg_o}, 32'd0);

        // LB from 0x100: grant in 3rd REQ cycle, done 3 cycles later
        stall_cnt = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c == 0)      drive(1'b1, OP_LB, 5'd7, 1'b0, 32'h0000_0100, 32'h0);
            else if (c == 1) drive(1'b1, OP_ADD, 5'd3, 1'b1, 32'hDEAD_0000, 32'h0);
            else             drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
            mem_gnt   = (c == 3);
            mem_done  = (c == 6) || (c == 2);
            mem_rdata = (c == 6) ? 32'h0000_0080 : 32'h0000_0011;
            #1;
            if (mem_stall_req) stall_cnt++;
            if (c == 1) check("lb_req", {31'd0, mem_req}, 32'd1);
            if (c == 1) check("lb_we_size", {29'd0, mem_we, mem_size}, {29'd0, 1'b0, SIZE_B});
            if (c == 2) check("lb_addr_hold", mem_addr, 32'h0000_0100);
            if (c == 4) check("lb_wait_noreq", {31'd0, mem_req}, 32'd0);
            if (c == 6) check("lb_done_nostall", {31'd0, mem_stall_req}, 32'd0);
            tick;
        end
        mem_gnt  = 1'b0;
        mem_done = 1'b0;
        check("lb_wdata", wdata_o, 32'hFFFF_FF80);
        check("lb_wreg", {31'd0, wreg_o}, 32'd1);
        check("lb_wd", {27'd0, wd_o}, 32'd7);
        check("lb_stall_cycles", stall_cnt, 32'd6);

        // SH 0x12345678 to 0x202, grant+done together
        drive(1'b1, OP_SH, 5'd4, 1'b1, 32'h0000_0202, 32'h1234_5678);
        #1;
        check("sh_issue_stall", {31'd0, mem_stall_req}, 32'd1);
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        check("sh_wdata", mem_wdata, 32'h0000_5678);
        check("sh_size", {30'd0, mem_size}, 32'd1);
        check("sh_we", {31'd0, mem_we}, 32'd1);
        check("sh_addr", mem_addr, 32'h0000_0202);
        mem_gnt  = 1'b1;
        mem_done = 1'b1;
        #1;
        check("sh_req", {31'd0, mem_req}, 32'd1);
        tick;
        mem_gnt  = 1'b0;
        mem_done = 1'b0;
        #1;
        check("sh_wreg", {31'd0, wreg_o}, 32'd0);
        check("sh_idle", {30'd0, mem_req, mem_stall_req}, 32'd0);

        // LHU then ADDI back-to-back
        drive(1'b1, OP_LHU, 5'd9, 1'b0, 32'h0000_0300, 32'h0);
        #1;
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        mem_gnt = 1'b1;
        #1;
        tick;
        mem_gnt   = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_F00D;
        #1;
        check("lhu_done_stall", {31'd0, mem_stall_req}, 32'd0);
        tick;
        mem_done = 1'b0;
        check("lhu_wdata", wdata_o, 32'h0000_F00D);
        check("lhu_wreg_wd", {26'd0, wd_o, wreg_o}, {26'd0, 5'd9, 1'b1});
        drive(1'b1, OP_ADDI, 5'd10, 1'b1, 32'h0000_0055, 32'h0);
        #1;
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        check("addi_wdata", wdata_o, 32'h0000_0055);
        check("addi_wreg_wd", {26'd0, wd_o, wreg_o}, {26'd0, 5'd10, 1'b1});

        // extension and masking table
        load_once("ext_lh", OP_LH, 32'h1234_F00D, 32'hFFFF_F00D);
        load_once("ext_lbu", OP_LBU, 32'hFFFF_FFAB, 32'h0000_00AB);
        load_once("ext_lb_pos", OP_LB, 32'hFFFF_FF7F, 32'h0000_007F);
        load_once("ext_lhu_hi", OP_LHU, 32'hABCD_8001, 32'h0000_8001);
        load_once("ext_lw", OP_LW, 32'h89AB_CDEF, 32'h89AB_CDEF);
        store_once("st_sb", OP_SB, 32'hAABB_CCDD, 32'h0000_00DD, SIZE_B);
        store_once("st_sw", OP_SW, 32'hAABB_CCDD, 32'hAABB_CCDD, SIZE_W);

        // reset while in REQ
        drive(1'b1, OP_LW, 5'd11, 1'b0, 32'h0000_0400, 32'h0);
        #1;
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rq_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("rq_req_async", {31'd0, mem_req}, 32'd0);
        check("rq_addr_async", mem_addr, 32'd0);
        rst = 1'b1;
        tick;

        // reset while in WAIT, then a late done and a stray grant
        drive(1'b1, OP_LW, 5'd11, 1'b0, 32'h0000_0404, 32'h0);
        #1;
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        mem_gnt = 1'b1;
        #1;
        tick;
        mem_gnt = 1'b0;
        #1;
        check("wt_stall_before", {31'd0, mem_stall_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("wt_stall_async", {31'd0, mem_stall_req}, 32'd0);
        check("wt_req_async", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_1234;
        #1;
        tick;
        mem_done = 1'b0;
        check("late_done_wreg", {31'd0, wreg_o}, 32'd0);
        check("late_done_wdata", wdata_o, 32'd0);
        mem_gnt = 1'b1;
        #1;
        tick;
        mem_gnt = 1'b0;
        check("stray_gnt", {30'd0, mem_req, mem_stall_req}, 32'd0);

        // LW to misaligned 0x103
        drive(1'b1, OP_LW, 5'd13, 1'b0, 32'h0000_0103, 32'h0);
        #1;
`ifdef MEM_MISALIGN_CHK_EN
        check("mis_stall", {31'd0, mem_stall_req}, 32'd0);
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        check("mis_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        check("mis_wreg", {31'd0, wreg_o}, 32'd0);
        tick;
        check("mis_flag_clear", {31'd0, misalign_o}, 32'd0);
`else
        check("mis_stall", {31'd0, mem_stall_req}, 32'd1);
        tick;
        drive(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
        check("mis_flag", {31'd0, misalign_o}, 32'd0);
        check("mis_req", {31'd0, mem_req}, 32'd1);
        check("mis_addr", mem_addr, 32'h0000_0103);
        mem_gnt   = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        tick;
        mem_gnt  = 1'b0;
        mem_done = 1'b0;
        check("mis_load", wdata_o, 32'hCAFE_F00D);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter XLEN, default 32, data and address width in bits.
REQ-002 Parameter REG_ADDR_W, default 5, register-index width.
REQ-003 Parameter OP_W, default 8, op-type width, matching the ALU select bus.
REQ-004 Ports SHALL be:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EX/MEM holds a valid instruction.
- op_i  in  OP_W  op type: LB/LH/LW/LBU/LHU/SB/SH/SW, or other (non-memory).
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  write-back enable.
- wdata_i  in  XLEN  ALU result; the effective address for memory ops.
- st_data_i  in  XLEN  store source data.
- mem_stall_req  out  1  stalls the pipeline.
- mem_req  out  1  request to mem_ctrl.
- mem_addr  out  XLEN  request address.
- mem_wdata  out  XLEN  store data, masked to size.
- mem_we  out  1  1 = store.
- mem_size  out  2  0 = byte, 1 = half, 2 = word.
- mem_gnt  in  1  mem_ctrl accepts the request.
- mem_done  in  1  transfer complete.
- mem_rdata  in  XLEN  load data, LSB-aligned, valid with mem_done.
- wd_o  out  REG_ADDR_W  registered write-back register index.
- wreg_o  out  1  registered write-back enable.
- wdata_o  out  XLEN  registered write-back data.
- misalign_o  out  1  one-cycle misaligned-access flag.

Function
REQ-005 FSM states SHALL be IDLE, REQ and WAIT.
REQ-006 In IDLE, an input with in_valid=1 and a non-memory op SHALL register wd_i/wreg_i/wdata_i to the outputs at the next edge (1-cycle latency), with no stall.
REQ-007 In IDLE, an input with in_valid=1 and a memory op SHALL latch op, address, data and wd_i, then go to REQ.
- mem_stall_req=1 combinationally in that same cycle.
- Outputs SHALL take wreg_o=0 at that edge.
REQ-008 In REQ, mem_req SHALL be 1 and mem_addr/mem_wdata/mem_we/mem_size SHALL be held stable until mem_gnt=1.
REQ-009 When mem_gnt=1 in REQ:
- the FSM SHALL go to WAIT;
- if mem_done=1 in the same cycle, the FSM SHALL complete directly to IDLE.
REQ-010 In WAIT, mem_req=0; the FSM SHALL stay in WAIT until mem_done=1.
REQ-011 Completion on the mem_done edge:
- Load: wd_o=latched wd, wreg_o=1, wdata_o=extended mem_rdata.
- Store: wreg_o=0.
- FSM returns to IDLE.
REQ-012 mem_stall_req = (IDLE & in_valid & memory op) | REQ | (WAIT & ~mem_done), so upstream advances in the completion cycle.
REQ-013 Load extension rules:
- LB: sign-extend bit 7.
- LBU: zero-extend bits 7:0.
- LH: sign-extend bit 15.
- LHU: zero-extend bits 15:0.
- LW: unchanged.
REQ-014 Store masking: mem_wdata SHALL be st_data_i with bits above the access size zeroed; mem_size SHALL be 0/1/2 for SB/SH/SW.
REQ-015 Outside IDLE, in_valid and all other inputs SHALL be ignored.
REQ-016 mem_gnt or mem_done arriving in a state that does not expect it SHALL be ignored.
REQ-017 When in_valid=0 in IDLE, the outputs SHALL take wreg_o=0 at the next edge.

Reset
REQ-018 rst=0 SHALL asynchronously force all of the following, aborting any in-flight request:
- FSM to IDLE;
- mem_req=0, mem_we=0, mem_size=0;
- mem_addr, mem_wdata, wdata_o = 0;
- wd_o=0, wreg_o=0, misalign_o=0.
REQ-019 The first edge after release SHALL behave as IDLE.

Configuration
REQ-020 Macro MEM_MISALIGN_CHK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, SHALL issue no request; it completes in 1 cycle with wreg_o=0, misalign_o=1 for that cycle, and mem_stall_req=0.
- Undefined: misalign_o SHALL be constant 0 and all accesses SHALL be issued unchanged.

Structure
REQ-021 Op codes, the mem_size encodings and the FSM state encodings SHALL live in the shared defines header.
REQ-022 Load extension and store masking SHALL be one combinational sub-module, mem_align.

Verification
REQ-023 Scenario: ADD result 0x00000010 to x5, in IDLE -> next cycle wd_o=5, wreg_o=1, wdata_o=0x10; stall never asserted.
REQ-024 Scenario: LB from 0x100; gnt after 2 cycles; done 3 cycles later with rdata=0x80 -> wdata_o=0xFFFFFF80; stall high for exactly 6 cycles.
REQ-025 Scenario: SH of st_data 0x12345678 to 0x202; gnt and done in the same cycle -> mem_wdata=0x5678, mem_size=1, mem_we=1; wreg_o=0; back to IDLE in 2 cycles.
REQ-026 Scenario: LHU returning rdata=0x0000F00D, immediately followed by an ADDI -> wdata_o=0x0000F00D, and the ADDI result appears on the very next cycle.
REQ-027 Scenario: rst=0 asserted while in WAIT -> mem_req=0 and FSM in IDLE with no clock edge; a late mem_done is ignored.
REQ-028 Scenario (with MEM_MISALIGN_CHK_EN): LW to 0x103 -> mem_req stays 0, misalign_o=1 for one cycle, wreg_o=0.
